// File: rtl/pe_row_sequencer.sv
// Row-stationary PE initiator/collector: stores one ifmap tile and one filter,
// drives FIL_S chained passes per output row into a single PE and streams finished rows out.
`timescale 1ns/1ps
module pe_row_sequencer #(
  parameter int INWIDTH = 16,
  parameter int FIL_S   = 3,
  parameter int DI_W    = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          filt_wr_en,
  input  logic [3:0]                    filt_wr_addr,
  input  logic signed [INWIDTH-1:0]     filt_wr_data,
  input  logic                          ifm_wr_en,
  input  logic [5:0]                    ifm_wr_addr,
  input  logic signed [INWIDTH-1:0]     ifm_wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          pe_start,
  output logic [FIL_S*INWIDTH-1:0]      pe_filter,
  output logic [DI_W*INWIDTH-1:0]       pe_data,
  output logic [(DI_W-FIL_S+1)*INWIDTH-1:0] pe_psum,
  input  logic                          pe_done,
  input  logic [(DI_W-FIL_S+1)*INWIDTH-1:0] pe_psum_in,
  output logic                          orow_valid,
  input  logic                          orow_ready,
  output logic [(DI_W-FIL_S+1)*INWIDTH-1:0] orow_data,
  output logic [2:0]                    orow_idx
);

  localparam int DO_W = DI_W - FIL_S + 1;
  localparam int KW   = (FIL_S > 1) ? $clog2(FIL_S) : 1;
  localparam logic [3:0]    FILT_N = 4'(FIL_S * FIL_S);
  localparam logic [5:0]    IFM_N  = 6'(DI_W * DI_W);
  localparam logic [KW-1:0] K_LAST = KW'(FIL_S - 1);
  localparam logic [2:0]    R_LAST = 3'(DO_W - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  state_t                     state, state_nx;
  logic signed [INWIDTH-1:0]  filt_mem [FIL_S*FIL_S];
  logic signed [INWIDTH-1:0]  ifm_mem  [DI_W*DI_W];
  logic [2:0]                 r, r_nx;
  logic [KW-1:0]              k, k_nx;
  logic [DO_W*INWIDTH-1:0]    psum_acc, acc_nx;
  logic                       issue_ld;
  logic                       last_hs;

  function automatic logic [FIL_S*INWIDTH-1:0] filt_row(input logic [KW-1:0] kk);
    logic [FIL_S*INWIDTH-1:0] row;
    row = '0;
    for (int j = 0; j < FIL_S; j++)
      row[j*INWIDTH +: INWIDTH] = filt_mem[4'(int'(kk) * FIL_S + j)];
    return row;
  endfunction

  function automatic logic [DI_W*INWIDTH-1:0] ifm_row(input logic [2:0] rr, input logic [KW-1:0] kk);
    logic [DI_W*INWIDTH-1:0] row;
    int base;
    row  = '0;
    base = (int'(rr) + int'(kk)) * DI_W;
    for (int c = 0; c < DI_W; c++)
      row[c*INWIDTH +: INWIDTH] = ifm_mem[6'(base + c)];
    return row;
  endfunction

  // Storage is loaded by the global buffer only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (filt_wr_en && state == IDLE && filt_wr_addr < FILT_N)
      filt_mem[filt_wr_addr] <= filt_wr_data;
    if (ifm_wr_en && state == IDLE && ifm_wr_addr < IFM_N)
      ifm_mem[ifm_wr_addr] <= ifm_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    k_nx     = k;
    issue_ld = 1'b0;
    last_hs  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          r_nx     = '0;
          k_nx     = '0;
          issue_ld = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (pe_done) begin
          if (k != K_LAST) begin
            state_nx = ISSUE;
            k_nx     = k + KW'(1);
            issue_ld = 1'b1;
          end else begin
            state_nx = EMIT;
          end
        end
      end
      EMIT: begin
        if (orow_ready) begin
          if (r != R_LAST) begin
            state_nx = ISSUE;
            r_nx     = r + 3'd1;
            k_nx     = '0;
            issue_ld = 1'b1;
          end else begin
            state_nx = IDLE;
            last_hs  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A returning partial sum feeds the very next pass, so it bypasses psum_acc here.
  assign acc_nx = (state == WAIT && pe_done) ? pe_psum_in : psum_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r         <= '0;
      k         <= '0;
      psum_acc  <= '0;
      done      <= 1'b0;
      pe_filter <= '0;
      pe_data   <= '0;
      pe_psum   <= '0;
    end else begin
      r        <= r_nx;
      k        <= k_nx;
      psum_acc <= acc_nx;
      done     <= last_hs;
      if (issue_ld) begin
        pe_filter <= filt_row(k_nx);
        pe_data   <= ifm_row(r_nx, k_nx);
        pe_psum   <= (k_nx == '0) ? '0 : acc_nx;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign pe_start   = (state == ISSUE);
  assign orow_valid = (state == EMIT);
  assign orow_data  = psum_acc;
  assign orow_idx   = r;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Bench for pe_row_sequencer: behavioural PE, tile-level convolution model and directed scenarios.
`timescale 1ns/1ps
module tb_pe_row_sequencer;
  localparam int W = 16, FS = 3, DW = 7, DOW = 5, L = 6;

  logic clk = 1'b0;
  logic rst;
  logic filt_wr_en, ifm_wr_en, start, busy, done, pe_start, pe_done, orow_valid, orow_ready;
  logic [3:0] filt_wr_addr;
  logic [5:0] ifm_wr_addr;
  logic signed [W-1:0] filt_wr_data, ifm_wr_data;
  logic [FS*W-1:0]  pe_filter;
  logic [DW*W-1:0]  pe_data;
  logic [DOW*W-1:0] pe_psum, pe_psum_in, orow_data;
  logic [2:0] orow_idx;

  pe_row_sequencer #(.INWIDTH(W), .FIL_S(FS), .DI_W(DW)) dut (
    .clk(clk), .rst(rst),
    .filt_wr_en(filt_wr_en), .filt_wr_addr(filt_wr_addr), .filt_wr_data(filt_wr_data),
    .ifm_wr_en(ifm_wr_en), .ifm_wr_addr(ifm_wr_addr), .ifm_wr_data(ifm_wr_data),
    .start(start), .busy(busy), .done(done),
    .pe_start(pe_start), .pe_filter(pe_filter), .pe_data(pe_data), .pe_psum(pe_psum),
    .pe_done(pe_done), .pe_psum_in(pe_psum_in),
    .orow_valid(orow_valid), .orow_ready(orow_ready), .orow_data(orow_data), .orow_idx(orow_idx)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int pass_cnt, row_ptr, done_cnt, first_cyc, done_cyc;
  bit prev_hs = 1'b0, spur_idle = 1'b0, spur_issue = 1'b0;
  logic signed [W-1:0] filt_m [FS*FS];
  logic signed [W-1:0] ifm_m  [DW*DW];
  logic [DOW*W-1:0] got_row [DOW];
  logic [DOW*W-1:0] ref_row [DOW];
  logic [DOW*W-1:0] pass_psum [FS*DOW];
  logic [DW*W-1:0]  pass_data [FS*DOW];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [FS*W-1:0] m_filt_row(input int kk);
    logic [FS*W-1:0] v;
    for (int j = 0; j < FS; j++) v[j*W +: W] = filt_m[kk*FS + j];
    return v;
  endfunction

  function automatic logic [DW*W-1:0] m_ifm_row(input int rr);
    logic [DW*W-1:0] v;
    for (int c = 0; c < DW; c++) v[c*W +: W] = ifm_m[rr*DW + c];
    return v;
  endfunction

  // Output row rr accumulated over filter rows 0..kmax-1, wrapped to W bits.
  function automatic logic [DOW*W-1:0] m_partial(input int rr, input int kmax);
    logic [DOW*W-1:0] v;
    int acc;
    v = '0;
    for (int c = 0; c < DOW; c++) begin
      acc = 0;
      for (int kk = 0; kk < kmax; kk++)
        for (int j = 0; j < FS; j++)
          acc += int'(filt_m[kk*FS + j]) * int'(ifm_m[(rr + kk)*DW + c + j]);
      v[c*W +: W] = acc[W-1:0];
    end
    return v;
  endfunction

  function automatic logic [DOW*W-1:0] pe_compute();
    logic [DOW*W-1:0] v;
    int acc;
    for (int c = 0; c < DOW; c++) begin
      acc = int'($signed(pe_psum[c*W +: W]));
      for (int j = 0; j < FS; j++)
        acc += int'($signed(pe_filter[j*W +: W])) * int'($signed(pe_data[(c + j)*W +: W]));
      v[c*W +: W] = acc[W-1:0];
    end
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural PE with fixed latency L, plus optional spurious pe_done pulses.
  initial begin
    int cnt;
    logic [DOW*W-1:0] res;
    cnt = 0;
    res = '0;
    pe_done = 1'b0;
    pe_psum_in = '0;
    forever begin
      @(posedge clk);
      #1;
      pe_done = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else begin
        if (spur_idle) begin
          pe_done = 1'b1;
          pe_psum_in = {DOW{16'hBEEF}};
          spur_idle = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            pe_done = 1'b1;
            pe_psum_in = res;
          end
        end
        if (pe_start) begin
          res = pe_compute();
          cnt = L;
          if (spur_issue) begin
            pe_done = 1'b1;
            pe_psum_in = {DOW{16'hDEAD}};
            spur_issue = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: operands of every pass and every presented output row.
  initial begin
    int re, ke;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) chk("resume_issue", pe_start, 1);
        prev_hs = 1'b0;
        if (pe_start) begin
          if (pass_cnt >= FS*DOW) begin
            chk("extra_pass", pass_cnt, FS*DOW - 1);
          end else begin
            re = pass_cnt / FS;
            ke = pass_cnt % FS;
            chk($sformatf("pe_filter_p%0d", pass_cnt), pe_filter, m_filt_row(ke));
            chk($sformatf("pe_data_p%0d", pass_cnt), pe_data, m_ifm_row(re + ke));
            chk($sformatf("pe_psum_p%0d", pass_cnt), pe_psum, m_partial(re, ke));
            pass_psum[pass_cnt] = pe_psum;
            pass_data[pass_cnt] = pe_data;
          end
          if (pass_cnt == 0) first_cyc = cyc;
          pass_cnt++;
        end
        if (orow_valid) begin
          chk("emit_no_issue", pe_start, 0);
          if (row_ptr < DOW) begin
            chk("orow_idx", orow_idx, row_ptr[2:0]);
            chk($sformatf("orow_data_r%0d", row_ptr), orow_data, m_partial(row_ptr, FS));
            if (orow_ready) begin
              got_row[row_ptr] = orow_data;
              row_ptr++;
              prev_hs = (row_ptr < DOW);
            end
          end else begin
            chk("extra_row", row_ptr, DOW - 1);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic reset_track();
    pass_cnt = 0; row_ptr = 0; done_cnt = 0; first_cyc = -1; done_cyc = -1;
  endtask

  task automatic wr_filt(input int a, input logic [15:0] v);
    filt_wr_en = 1'b1; filt_wr_addr = 4'(a); filt_wr_data = v; filt_m[a] = v;
    @(posedge clk); #1;
    filt_wr_en = 1'b0;
  endtask

  task automatic wr_ifm(input int a, input logic [15:0] v);
    ifm_wr_en = 1'b1; ifm_wr_addr = 6'(a); ifm_wr_data = v; ifm_m[a] = v;
    @(posedge clk); #1;
    ifm_wr_en = 1'b0;
  endtask

  task automatic run_tile(input int stall_row, input int stall_n, input bit inject, input int exp_len);
    int n, left;
    reset_track();
    left = stall_n;
    start = 1'b1;
    if (inject) spur_issue = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      if (left > 0 && (left < stall_n || (orow_valid && int'(orow_idx) == stall_row))) begin
        chk("stall_valid", orow_valid, 1);
        chk("stall_idx", orow_idx, 3'(stall_row));
        orow_ready = 1'b0;
        left--;
      end else begin
        orow_ready = 1'b1;
      end
      if (inject && n == 4) begin
        start = 1'b1; ifm_wr_en = 1'b1; ifm_wr_addr = 6'd0; ifm_wr_data = 16'h1234;
      end else if (inject && n == 5) begin
        start = 1'b0; ifm_wr_en = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    orow_ready = 1'b1;
    chk("tile_complete", done_cnt > 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("idle_after", busy, 0);
    chk("rows_out", row_ptr, DOW);
    chk("passes", pass_cnt, FS*DOW);
    chk("tile_len", done_cyc - first_cyc, exp_len);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; orow_ready = 1'b1;
    filt_wr_en = 1'b0; filt_wr_addr = '0; filt_wr_data = '0;
    ifm_wr_en = 1'b0; ifm_wr_addr = '0; ifm_wr_data = '0;
    reset_track();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_pe_start", pe_start, 0); chk("rst_orow_valid", orow_valid, 0);
    chk("rst_pe_filter", pe_filter, 0); chk("rst_pe_data", pe_data, 0);
    chk("rst_pe_psum", pe_psum, 0);   chk("rst_orow_data", orow_data, 0);
    chk("rst_orow_idx", orow_idx, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Scenario 1/2: all-ones filter over a ramp ifmap.
    for (int i = 0; i < FS*FS; i++) wr_filt(i, 16'd1);
    for (int rr = 0; rr < DW; rr++)
      for (int c = 0; c < DW; c++) wr_ifm(rr*DW + c, 16'(7*rr + c));
    chk("model_pin_row0", m_partial(0, FS), {16'd108, 16'd99, 16'd90, 16'd81, 16'd72});
    run_tile(-1, 0, 1'b0, 110);
    chk("row0_literal", got_row[0], {16'd108, 16'd99, 16'd90, 16'd81, 16'd72});
    chk("row4_literal", got_row[4], {16'd360, 16'd351, 16'd342, 16'd333, 16'd324});
    chk("p0_psum_zero", pass_psum[0], 0);
    chk("p9_psum_zero", pass_psum[9], 0);
    chk("p7_data_lane0", pass_data[7][15:0], 16'd21);
    chk("p7_psum_lane0", pass_psum[7][15:0], 16'd45);
    chk("p7_psum_lane4", pass_psum[7][79:64], 16'd57);
    for (int i = 0; i < DOW; i++) ref_row[i] = got_row[i];

    // Scenario 3: downstream stall on row 1.
    run_tile(1, 20, 1'b0, 130);

    // Scenario 4: spurious pe_done, start and write while busy.
    spur_idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_idle_busy", busy, 0);
    chk("spur_idle_valid", orow_valid, 0);
    run_tile(-1, 0, 1'b1, 110);
    for (int i = 0; i < DOW; i++) chk($sformatf("inject_row%0d", i), got_row[i], ref_row[i]);

    // Scenario 5: asynchronous reset during row 2, then restart from retained storage.
    reset_track();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 500 && !(pass_cnt == 7 && busy && !pe_start); n++) begin
      @(posedge clk); #1;
    end
    chk("reached_row2_wait", pass_cnt, 7);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);         chk("abort_pe_start", pe_start, 0);
    chk("abort_orow_valid", orow_valid, 0); chk("abort_pe_filter", pe_filter, 0);
    chk("abort_pe_data", pe_data, 0);   chk("abort_pe_psum", pe_psum, 0);
    chk("abort_orow_data", orow_data, 0); chk("abort_orow_idx", orow_idx, 0);
    chk("abort_done", done, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    run_tile(-1, 0, 1'b0, 110);
    for (int i = 0; i < DOW; i++) chk($sformatf("restart_row%0d", i), got_row[i], ref_row[i]);

    // Scenario 6: centre-tap identity filter over a saturated ifmap.
    for (int i = 0; i < FS*FS; i++) wr_filt(i, (i == 4) ? 16'd1 : 16'd0);
    for (int i = 0; i < DW*DW; i++) wr_ifm(i, 16'h7FFF);
    run_tile(-1, 0, 1'b0, 110);
    for (int rr = 0; rr < DOW; rr++)
      for (int c = 0; c < DOW; c++)
        chk($sformatf("ident_r%0d_lane%0d", rr, c), got_row[rr][c*W +: W], 16'h7FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
